// File: rtl/instr_fetch_ooo_guard_if.sv
// Handshake bundle for the fetch stage: PC in, memory request/response, fetched {pc, instr} out.
// The master modport is the fetch stage; the slave modport is its environment.
interface instr_fetch_ooo_guard_if #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned INSTR_WIDTH = 32
);
  logic                              pc_valid;
  logic                              pc_ready;
  logic [ADDR_WIDTH-1:0]             pc_data;
  logic                              mem_req_valid;
  logic                              mem_req_ready;
  logic [ADDR_WIDTH-1:0]             mem_req_data;
  logic                              mem_resp_valid;
  logic                              mem_resp_ready;
  logic [INSTR_WIDTH-1:0]            mem_resp_data;
  logic                              fetched_valid;
  logic                              fetched_ready;
  logic [ADDR_WIDTH+INSTR_WIDTH-1:0] fetched_data;

  modport master (
    input  pc_valid, pc_data, mem_req_ready, mem_resp_valid, mem_resp_data, fetched_ready,
    output pc_ready, mem_req_valid, mem_req_data, mem_resp_ready, fetched_valid, fetched_data
  );

  modport slave (
    output pc_valid, pc_data, mem_req_ready, mem_resp_valid, mem_resp_data, fetched_ready,
    input  pc_ready, mem_req_valid, mem_req_data, mem_resp_ready, fetched_valid, fetched_data
  );
endinterface

// File: rtl/instr_fetch_ooo_guard.sv
// Fetch stage: issues in-order instruction reads, pairs each response with its PC, drops
// responses made stale by flush, and reserves output buffer space per issued request so the
// memory response channel never needs back-pressure.
// Optional macro FETCH_PERF_CNT_EN adds saturating issue/drop/credit-stall counters.
module instr_fetch_ooo_guard #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned INSTR_WIDTH     = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned BUF_DEPTH       = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  instr_fetch_ooo_guard_if.master bus,
  output logic                  busy
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           perf_issued,
  output logic [31:0]           perf_dropped,
  output logic [31:0]           perf_credit_stall
`endif
);
  localparam int unsigned CntW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned OccW  = $clog2(BUF_DEPTH + 1);
  localparam int unsigned TagPw = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned BufPw = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned FetW  = ADDR_WIDTH + INSTR_WIDTH;

  logic                  active_q;
  logic [CntW-1:0]       total_q, stale_q, live;
  logic [OccW-1:0]       occ_q;
  logic [TagPw-1:0]      tag_rd_q, tag_wr_q;
  logic [BufPw-1:0]      buf_rd_q, buf_wr_q;
  logic [ADDR_WIDTH-1:0] tag_mem [MAX_OUTSTANDING];
  logic [FetW-1:0]       buf_mem [BUF_DEPTH];
  logic                  permit, req_fire, resp_fire, resp_take, resp_keep, deq;

  function automatic logic [TagPw-1:0] tag_inc(input logic [TagPw-1:0] p);
    return (32'(p) == MAX_OUTSTANDING - 1) ? '0 : p + TagPw'(1);
  endfunction

  function automatic logic [BufPw-1:0] buf_inc(input logic [BufPw-1:0] p);
    return (32'(p) == BUF_DEPTH - 1) ? '0 : p + BufPw'(1);
  endfunction

  // Every live request holds one buffer credit, so a kept response always finds a free slot.
  assign live   = total_q - stale_q;
  assign permit = active_q && !flush && (32'(total_q) < MAX_OUTSTANDING) &&
                  (32'(live) + 32'(occ_q) < BUF_DEPTH);

  assign bus.mem_req_valid  = bus.pc_valid && permit;
  assign bus.pc_ready       = bus.mem_req_ready && permit;
  assign bus.mem_req_data   = bus.pc_data;
  assign bus.mem_resp_ready = active_q;
  assign bus.fetched_valid  = active_q && (occ_q != '0) && !flush;
  assign bus.fetched_data   = buf_mem[buf_rd_q];
  assign busy               = (total_q != '0);

  assign req_fire  = bus.mem_req_valid && bus.mem_req_ready;
  assign resp_fire = bus.mem_resp_valid && bus.mem_resp_ready;
  // A response with nothing outstanding is ignored entirely.
  assign resp_take = resp_fire && (total_q != '0);
  assign resp_keep = resp_take && (stale_q == '0) && !flush;
  assign deq       = bus.fetched_valid && bus.fetched_ready;

  // Counters, FIFO pointers and the out-of-reset flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_q <= 1'b0;
      total_q  <= '0;
      stale_q  <= '0;
      occ_q    <= '0;
      tag_rd_q <= '0;
      tag_wr_q <= '0;
      buf_rd_q <= '0;
      buf_wr_q <= '0;
    end else begin
      active_q <= 1'b1;
      total_q  <= total_q + CntW'(req_fire) - CntW'(resp_take);
      if (req_fire)  tag_wr_q <= tag_inc(tag_wr_q);
      if (resp_take) tag_rd_q <= tag_inc(tag_rd_q);
      if (flush) begin
        // Nothing issues in a flush cycle, so everything still outstanding becomes stale.
        stale_q  <= total_q - CntW'(resp_take);
        occ_q    <= '0;
        buf_rd_q <= '0;
        buf_wr_q <= '0;
      end else begin
        if (resp_take && (stale_q != '0)) stale_q <= stale_q - CntW'(1);
        occ_q <= occ_q + OccW'(resp_keep) - OccW'(deq);
        if (resp_keep) buf_wr_q <= buf_inc(buf_wr_q);
        if (deq)       buf_rd_q <= buf_inc(buf_rd_q);
      end
    end
  end

  // Tag and output buffer storage; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (req_fire)  tag_mem[tag_wr_q] <= bus.pc_data;
    if (resp_keep) buf_mem[buf_wr_q] <= {tag_mem[tag_rd_q], bus.mem_resp_data};
  end

  resp_without_request: assert property (@(posedge clk) disable iff (!rst)
    !(resp_fire && (total_q == '0)));
  buffer_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(resp_keep && !deq && (32'(occ_q) >= BUF_DEPTH)));
  stale_exceeds_total: assert property (@(posedge clk) disable iff (!rst)
    (stale_q <= total_q));

`ifdef FETCH_PERF_CNT_EN
  logic resp_drop, credit_stall;
  assign resp_drop    = resp_take && ((stale_q != '0) || flush);
  assign credit_stall = active_q && bus.pc_valid && !flush && !permit;

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_issued       <= '0;
      perf_dropped      <= '0;
      perf_credit_stall <= '0;
    end else begin
      if (req_fire && (perf_issued != '1))           perf_issued       <= perf_issued + 32'd1;
      if (resp_drop && (perf_dropped != '1))         perf_dropped      <= perf_dropped + 32'd1;
      if (credit_stall && (perf_credit_stall != '1)) perf_credit_stall <= perf_credit_stall + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_instr_fetch_ooo_guard.sv
// Randomised bench for instr_fetch_ooo_guard with an in-order memory model and a queue-based
// reference of in-flight requests and expected fetched words.
module tb_instr_fetch_ooo_guard;
  localparam int unsigned AW   = 32;
  localparam int unsigned IW   = 32;
  localparam int unsigned MAXO = 4;
  localparam int unsigned BUFD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic busy;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_issued, perf_dropped, perf_credit_stall;
`endif

  always #5 clk = ~clk;

  instr_fetch_ooo_guard_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) bus ();

  instr_fetch_ooo_guard #(
    .ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .MAX_OUTSTANDING(MAXO), .BUF_DEPTH(BUFD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .bus(bus),
    .busy(busy)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_issued(perf_issued),
    .perf_dropped(perf_dropped),
    .perf_credit_stall(perf_credit_stall)
`endif
  );

  typedef struct {
    logic [AW-1:0] addr;
    int            due;
  } mem_ent_t;

  // Reference: outstanding requests (with stale flag) and words expected on fetched, in order.
  logic [AW-1:0]    inflight_pc[$];
  bit               inflight_stale[$];
  logic [AW+IW-1:0] exp_q[$];
  mem_ent_t         memq[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int m_issued = 0, m_dropped = 0, m_stall = 0, phase_issues = 0;
  int p_pc = 0, p_mrdy = 0, p_frdy = 0, p_flush = 0, lat_max = 0;
  bit resp_en = 1'b1;
  logic [AW-1:0] next_pc = '0;

  function automatic logic [IW-1:0] instr_of(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares each fetched transfer against the head of the expected queue.
  always @(negedge clk) begin
    logic [AW+IW-1:0] e;
    #2;
    chk("fetched_valid", 64'(bus.fetched_valid), 64'((exp_q.size() != 0) && !flush && rst));
    if (bus.fetched_valid && bus.fetched_ready) begin
      if (exp_q.size() == 0) begin
        chk("fetched_unexpected", 64'(bus.fetched_data), 64'hx);
      end else begin
        e = exp_q.pop_front();
        chk("fetched_data", 64'(bus.fetched_data), 64'(e));
      end
    end
  end

  task automatic step();
    bit            permit;
    bit            stale;
    int            live;
    logic [AW-1:0] tpc;
    @(negedge clk);
    flush              = ($urandom_range(99) < p_flush);
    bus.pc_valid       = ($urandom_range(99) < p_pc);
    bus.pc_data        = next_pc;
    bus.mem_req_ready  = ($urandom_range(99) < p_mrdy);
    bus.fetched_ready  = ($urandom_range(99) < p_frdy);
    if (resp_en && memq.size() != 0 && memq[0].due <= cyc) begin
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = instr_of(memq[0].addr);
    end else begin
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_data  = $urandom;
    end
    #1;
    live = 0;
    foreach (inflight_stale[i]) if (!inflight_stale[i]) live++;
    permit = !flush && (inflight_pc.size() < MAXO) && (live + exp_q.size() < BUFD);
    chk("mem_resp_ready", 64'(bus.mem_resp_ready), 64'd1);
    chk("busy", 64'(busy), 64'(inflight_pc.size() != 0));
    chk("mem_req_valid", 64'(bus.mem_req_valid), 64'(bus.pc_valid && permit));
    chk("pc_ready", 64'(bus.pc_ready), 64'(bus.mem_req_ready && permit));
    if (bus.mem_req_valid) chk("mem_req_data", 64'(bus.mem_req_data), 64'(next_pc));
    #2;
    // Memory follows the real handshakes; the reference follows the rules.
    if (bus.mem_resp_valid && bus.mem_resp_ready) void'(memq.pop_front());
    if (bus.mem_req_valid && bus.mem_req_ready) begin
      memq.push_back('{addr: bus.mem_req_data, due: cyc + 1 + int'($urandom_range(lat_max))});
      phase_issues++;
    end
    if (bus.mem_resp_valid && inflight_pc.size() != 0) begin
      tpc   = inflight_pc.pop_front();
      stale = inflight_stale.pop_front();
      if (stale || flush) m_dropped++;
      else exp_q.push_back({tpc, instr_of(tpc)});
    end
    if (bus.pc_valid && bus.mem_req_ready && permit) begin
      inflight_pc.push_back(bus.pc_data);
      inflight_stale.push_back(1'b0);
      m_issued++;
    end
    if (flush) begin
      foreach (inflight_stale[i]) inflight_stale[i] = 1'b1;
      exp_q.delete();
    end
    if (bus.pc_valid && !flush && !permit) m_stall++;
    if (bus.pc_valid && bus.pc_ready) next_pc = next_pc + 32'd4;
    cyc++;
  endtask

  task automatic knobs(input int pc_p, input int mrdy_p, input int frdy_p, input int fl_p,
                       input int lat, input bit ren);
    p_pc = pc_p; p_mrdy = mrdy_p; p_frdy = frdy_p; p_flush = fl_p; lat_max = lat; resp_en = ren;
  endtask

  task automatic drain();
    int n;
    knobs(0, 100, 100, 0, 0, 1'b1);
    n = 0;
    while ((inflight_pc.size() != 0 || exp_q.size() != 0) && n < 100) begin
      step();
      n++;
    end
    chk("drain_empty", 64'(inflight_pc.size() + exp_q.size()), 64'd0);
  endtask

  // Asserts reset between clock edges, checks outputs at once, then restarts from new_pc.
  task automatic do_reset(input logic [AW-1:0] new_pc);
    rst = 1'b0;
    #1;
    chk("rst_mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
    chk("rst_pc_ready", 64'(bus.pc_ready), 64'd0);
    chk("rst_fetched_valid", 64'(bus.fetched_valid), 64'd0);
    chk("rst_mem_resp_ready", 64'(bus.mem_resp_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    inflight_pc.delete();
    inflight_stale.delete();
    exp_q.delete();
    memq.delete();
    m_issued = 0; m_dropped = 0; m_stall = 0;
    flush = 1'b0;
    bus.pc_valid = 1'b0; bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0;
    bus.fetched_ready = 1'b0;
    next_pc = new_pc;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    bus.pc_valid = 1'b0; bus.pc_data = '0; bus.mem_req_ready = 1'b0;
    bus.mem_resp_valid = 1'b0; bus.mem_resp_data = '0; bus.fetched_ready = 1'b0;
    #1;
    do_reset(32'h0);

    // Streaming, latency 1, always ready.
    knobs(100, 100, 100, 0, 0, 1'b1);
    repeat (30) step();
    drain();

    // Memory silent: exactly MAXO issues, then credit stall.
    phase_issues = 0;
    knobs(100, 100, 100, 0, 0, 1'b0);
    repeat (12) step();
    chk("credit_issues", 64'(phase_issues), 64'(MAXO));
    chk("credit_busy", 64'(busy), 64'd1);

    // Flush in the same cycle as a response and a valid pc, then refetch from 0x200.
    knobs(100, 100, 100, 100, 0, 1'b1);
    step();
    next_pc = 32'h200;
    knobs(100, 100, 100, 0, 1, 1'b1);
    repeat (20) step();
    drain();

    // Output back-pressure, then release.
    knobs(100, 100, 0, 0, 0, 1'b1);
    repeat (15) step();
    knobs(100, 100, 100, 0, 0, 1'b1);
    repeat (10) step();
    drain();

    // Random mix with occasional flushes.
    for (int blk = 0; blk < 12; blk++) begin
      knobs(int'($urandom_range(100, 30)), int'($urandom_range(100, 30)),
            int'($urandom_range(100)), int'($urandom_range(10)), int'($urandom_range(4)),
            ($urandom_range(9) != 0));
      repeat (50) step();
    end
    drain();

    // Reset mid-stream, then resume from a fresh pc.
    knobs(100, 100, 30, 0, 2, 1'b1);
    repeat (8) step();
    do_reset(32'h4000);
    knobs(100, 100, 100, 0, 1, 1'b1);
    repeat (20) step();
    drain();

`ifdef FETCH_PERF_CNT_EN
    chk("perf_issued", 64'(perf_issued), 64'(m_issued));
    chk("perf_dropped", 64'(perf_dropped), 64'(m_dropped));
    chk("perf_credit_stall", 64'(perf_credit_stall), 64'(m_stall));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/instr_fetch_ooo_guard.md
Name: instr_fetch_ooo_guard

Overview:
Parametrised successor fetch stage between PC generation and decode. Issues up to MAX_OUTSTANDING in-order instruction memory requests and pairs each response with its PC. Implements flush by discarding stale in-flight responses. Credit-reserves output buffer space so mem_resp is never back-pressured.

Parameters:
ADDR_WIDTH, 32, PC / memory address width
INSTR_WIDTH, 32, instruction word width
MAX_OUTSTANDING, 4, max requests issued but not yet responded (live + stale), >=1
BUF_DEPTH, 4, output buffer entries, >=1

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
flush  in  1  discard all in-flight and buffered fetches this cycle
pc  decoupled.in  ADDR_WIDTH  next fetch address
mem_req  decoupled.out  ADDR_WIDTH  memory read address
mem_resp  decoupled.in  INSTR_WIDTH  memory read data, strictly in request order
fetched  decoupled.out  ADDR_WIDTH+INSTR_WIDTH  {pc, instr}, pc in MSBs
busy  out  1  any request in flight (total != 0)

Behaviour:
- State: total (in-flight count, 0..MAX_OUTSTANDING); stale (in-flight count to drop, 0..total); tag FIFO (depth MAX_OUTSTANDING) of issued PCs; output buffer (depth BUF_DEPTH) with occupancy occ.
- Counter widths: $clog2(N+1). No wrap; overflow/underflow is a design error, flagged by assertion.
- live = total - stale.
- Issue permitted when: !flush, total < MAX_OUTSTANDING, and live + occ < BUF_DEPTH.
- mem_req.valid = pc.valid && issue permitted; pc.ready = mem_req.ready && issue permitted. The pc handshake completes only when mem_req fires.
- mem_req.data = pc.data (combinational pass-through).
- On mem_req fire: push pc.data into tag FIFO; total +1.
- mem_resp.ready = 1 whenever out of reset (space is guaranteed by credits).
- On mem_resp fire: pop tag FIFO; total -1.
  - If stale > 0: drop the word; stale -1.
  - Else: enqueue {tag, data} into the output buffer.
- Simultaneous fire and response: total unchanged.
- Latency: response accepted in cycle N -> fetched.valid in N+1 (registered buffer). No combinational mem_resp -> fetched path.
- fetched.valid = occ != 0 && !flush. Dequeue on fetched fire.
- flush in cycle N:
  - No issue in cycle N.
  - Output buffer cleared at edge N+1.
  - fetched.valid forced 0 in cycle N.
  - stale at N+1 = total after cycle N's response retirement (every outstanding request becomes stale).
  - A response arriving in cycle N is never enqueued.
  - Back-to-back flushes are idempotent.
- Reset (async assert, any time, including mid-operation):
  - total = stale = occ = 0; tag FIFO empty.
  - mem_req.valid = 0, pc.ready = 0, fetched.valid = 0, mem_resp.ready = 0, busy = 0.
  - Responses to pre-reset requests are the memory's responsibility (memory is reset together).
- mem_resp.fire with total == 0: assertion failure; response ignored.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds three outputs, each 32 bits, cleared on reset, saturating at all-ones:
  - perf_issued: mem_req fires
  - perf_dropped: responses discarded due to stale > 0 or arriving during a flush cycle
  - perf_credit_stall: cycles with pc.valid && !flush && issue not permitted
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Streaming, mem latency 1, fetched.ready=1, PCs 0x0,0x4,0x8,0xC -> fetched {0x0,I0},{0x4,I1},{0x8,I2},{0xC,I3} in order; each one cycle after its response; mem_resp.ready never low.
- Credit limit, mem never responds, MAX_OUTSTANDING=4 -> exactly 4 mem_req fires; pc.ready=0 on the fifth; busy=1; perf_credit_stall increments per cycle.
- Buffer back-pressure, BUF_DEPTH=2, fetched.ready=0, instant responses -> at most 2 issues; live+occ never exceeds 2; no response lost after fetched.ready=1.
- Flush with 3 in flight (PCs 0x100,0x104,0x108) plus 1 buffered, then fetch 0x200 -> the 3 old responses dropped (perf_dropped=3); buffered entry gone; first fetched = {0x200, I}.
- Flush concurrent with a response and a valid pc in the same cycle -> response not enqueued; mem_req.valid=0 that cycle; stale equals remaining total.
- Async reset asserted mid-stream with 2 in flight and occ=1 -> all outputs low immediately; after release, total=stale=occ=0 and fetching resumes from the new pc.
